imm_enc: RTL and testbench
==========================

Name: imm_enc

Overview:
- Instruction assembler. Inverse of the core's immediate decode: packs opcode, register fields, funct fields and a 32-bit immediate into a 32-bit RV32I instruction word.
- Used by the debug/boot loader path and by testbench stimulus generators.
- Two-stage valid/ready pipeline with immediate range checking and statistics counters.

Parameters:
CNTW, 16, width of the encoded-instruction and error counters.

Ports:
CLK  in  1  clock, rising edge
RES  in  1  reset, asynchronous, active-low
IVALID  in  1  input request valid
IREADY  out  1  input request accepted this cycle when IVALID&IREADY
OPCODE  in  7  instruction opcode [6:0]
RD  in  5  destination register
RS1  in  5  source register 1
RS2  in  5  source register 2
FUNCT3  in  3  funct3 field
FUNCT7  in  7  funct7 field (R-type only)
IMM  in  32  byte-offset/value immediate, two's complement
OVALID  out  1  encoded word valid
OREADY  in  1  downstream accepts when OVALID&OREADY
ODATA  out  32  encoded instruction
OERR  out  1  immediate out of range or misaligned; qualified by OVALID
ENCCNT  out  CNTW  count of words delivered (OVALID&OREADY), wraps
ERRCNT  out  CNTW  count of delivered words with OERR=1, saturates at all-ones

Behaviour:
- Reset (RES=0, async): s1/s2 valid cleared; OVALID=0, ODATA=0, OERR=0, ENCCNT=0, ERRCNT=0. Asserting reset mid-transfer discards all in-flight requests. IREADY=1 once RES=1.
- Stage 1 registers the request fields. Stage 2 registers ODATA/OERR. A word accepted in cycle N is on ODATA in cycle N+2 if OREADY is held high.
- Each stage loads when it is empty or its contents advance in the same cycle. IREADY = !s1_valid | (s1 advances). No combinational path from IVALID to OVALID.
- Full throughput: 1 word/cycle with OREADY=1.
- With OREADY=0 and both stages full, IREADY=0. ODATA/OERR hold stable while OVALID&!OREADY.
- Format select by OPCODE:
  - 0100011 S: {IMM[11:5],RS2,RS1,FUNCT3,IMM[4:0],OPCODE}
  - 1100011 B: {IMM[12],IMM[10:5],RS2,RS1,FUNCT3,IMM[4:1],IMM[11],OPCODE}
  - 1101111 J: {IMM[20],IMM[10:1],IMM[11],IMM[19:12],RD,OPCODE}
  - 0110111/0010111 U: {IMM[31:12],RD,OPCODE}
  - 0000011, 0010011, 1100111 I: {IMM[11:0],RS1,FUNCT3,RD,OPCODE}
  - all others R: {FUNCT7,RS2,RS1,FUNCT3,RD,OPCODE}
- Range/alignment rules (OERR=1 if violated):
  - I/S: IMM[31:11] all equal.
  - B: IMM[31:12] all equal and IMM[0]=0.
  - J: IMM[31:20] all equal and IMM[0]=0.
  - U: IMM[11:0]=0.
  - R: never.
- On error the word is still emitted using the truncated fields as above. Error words are never dropped.
- Counters:
  - ENCCNT increments on each OVALID&OREADY and wraps from all-ones to 0.
  - ERRCNT increments on OVALID&OREADY&OERR and holds at all-ones.
  - Both update in the same cycle when their conditions coincide.
- Round-trip property: for any legal IMM, the core's immediate decode applied to ODATA returns IMM (SIMM path for S/B/J/I; U returns IMM exactly).

Test Plan:
1. Reset, then IVALID=1 with OPCODE=0010011, RD=1, RS1=2, FUNCT3=0, IMM=-1 (ADDI x1,x2,-1), OREADY=1 -> ODATA=0xFFF10093, OERR=0 two cycles after acceptance; ENCCNT=1.
2. B-type: OPCODE=1100011, RS1=1, RS2=2, FUNCT3=0, IMM=-4 -> ODATA=0xFE208EE3, OERR=0. Repeat with IMM=3 -> OERR=1, ERRCNT=1.
3. J-type: OPCODE=1101111, RD=1, IMM=0x800 -> ODATA=0x001000EF. Then IMM=0x100000 -> OERR=1.
4. U-type: OPCODE=0110111, RD=5, IMM=0x12345000 -> ODATA=0x123452B7. IMM=0x12345001 -> OERR=1, ODATA unchanged in the upper field.
5. Backpressure: stream 5 requests with OREADY=0 -> IREADY drops after 2 accepted, ODATA stable. Release OREADY -> all 5 delivered in order, 1 per cycle, ENCCNT=5.
6. Assert RES low with both stages full -> OVALID=0, counters=0 immediately (asynchronous). Random legal requests fed through the core's decode -> IMM recovered for 10k vectors.

Source files
------------

// File: rtl/imm_enc.sv
// imm_enc: RV32I instruction assembler. Packs opcode, register/funct fields and a
// 32-bit immediate into an instruction word through a two-stage valid/ready pipe.
module imm_enc #(
  parameter int unsigned CNTW = 16
) (
  input  logic            CLK,
  input  logic            RES,
  input  logic            IVALID,
  output logic            IREADY,
  input  logic [6:0]      OPCODE,
  input  logic [4:0]      RD,
  input  logic [4:0]      RS1,
  input  logic [4:0]      RS2,
  input  logic [2:0]      FUNCT3,
  input  logic [6:0]      FUNCT7,
  input  logic [31:0]     IMM,
  output logic            OVALID,
  input  logic            OREADY,
  output logic [31:0]     ODATA,
  output logic            OERR,
  output logic [CNTW-1:0] ENCCNT,
  output logic [CNTW-1:0] ERRCNT
);

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_t;

  logic        s1_valid;
  logic [6:0]  s1_op;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_f3;
  logic [6:0]  s1_f7;
  logic [31:0] s1_imm;

  fmt_t        fmt;
  logic [31:0] enc_word;
  logic        enc_err;
  logic        i_ok;
  logic        b_ok;
  logic        j_ok;
  logic        u_ok;

  logic        s2_ready;
  logic        s1_adv;
  logic        in_fire;
  logic        out_fire;

  // Handshake: each stage loads when empty or when its contents leave this cycle.
  assign s2_ready = !OVALID || OREADY;
  assign s1_adv   = s1_valid && s2_ready;
  assign IREADY   = !s1_valid || s1_adv;
  assign in_fire  = IVALID && IREADY;
  assign out_fire = OVALID && OREADY;

  always_comb begin
    fmt = FMT_R;
    unique case (s1_op)
      7'b0100011:             fmt = FMT_S;
      7'b1100011:             fmt = FMT_B;
      7'b1101111:             fmt = FMT_J;
      7'b0110111, 7'b0010111: fmt = FMT_U;
      7'b0000011, 7'b0010011,
      7'b1100111:             fmt = FMT_I;
      default:                fmt = FMT_R;
    endcase
  end

  // An immediate fits when every bit above the field's sign bit copies it.
  assign i_ok = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
  assign b_ok = ((&s1_imm[31:12]) || !(|s1_imm[31:12])) && !s1_imm[0];
  assign j_ok = ((&s1_imm[31:20]) || !(|s1_imm[31:20])) && !s1_imm[0];
  assign u_ok = !(|s1_imm[11:0]);

  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    unique case (fmt)
      FMT_S: begin
        enc_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
        enc_err  = !i_ok;
      end
      FMT_B: begin
        enc_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                    s1_imm[4:1], s1_imm[11], s1_op};
        enc_err  = !b_ok;
      end
      FMT_J: begin
        enc_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_op};
        enc_err  = !j_ok;
      end
      FMT_U: begin
        enc_word = {s1_imm[31:12], s1_rd, s1_op};
        enc_err  = !u_ok;
      end
      FMT_I: begin
        enc_word = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
        enc_err  = !i_ok;
      end
      default: begin
        enc_word = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op};
        enc_err  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_rd    <= '0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
      s1_f3    <= '0;
      s1_f7    <= '0;
      s1_imm   <= '0;
    end else begin
      if (IREADY) begin
        s1_valid <= IVALID;
      end
      if (in_fire) begin
        s1_op  <= OPCODE;
        s1_rd  <= RD;
        s1_rs1 <= RS1;
        s1_rs2 <= RS2;
        s1_f3  <= FUNCT3;
        s1_f7  <= FUNCT7;
        s1_imm <= IMM;
      end
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      OVALID <= 1'b0;
      ODATA  <= '0;
      OERR   <= 1'b0;
    end else if (s2_ready) begin
      OVALID <= s1_valid;
      if (s1_valid) begin
        ODATA <= enc_word;
        OERR  <= enc_err;
      end
    end
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      ENCCNT <= '0;
      ERRCNT <= '0;
    end else if (out_fire) begin
      ENCCNT <= ENCCNT + CNTW'(1);
      if (OERR && !(&ERRCNT)) begin
        ERRCNT <= ERRCNT + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_imm_enc.sv
// Bench for imm_enc: directed vector table, backpressure/reset sequences and a
// randomized run checked by decoding the emitted words back to immediates.
module tb_imm_enc;
  localparam int unsigned CNTW = 4;

  logic            CLK = 1'b0;
  logic            RES = 1'b0;
  logic            IVALID = 1'b0;
  logic            IREADY;
  logic [6:0]      OPCODE = '0;
  logic [4:0]      RD = '0;
  logic [4:0]      RS1 = '0;
  logic [4:0]      RS2 = '0;
  logic [2:0]      FUNCT3 = '0;
  logic [6:0]      FUNCT7 = '0;
  logic [31:0]     IMM = '0;
  logic            OVALID;
  logic            OREADY = 1'b0;
  logic [31:0]     ODATA;
  logic            OERR;
  logic [CNTW-1:0] ENCCNT;
  logic [CNTW-1:0] ERRCNT;

  always #5 CLK = ~CLK;

  imm_enc #(.CNTW(CNTW)) dut (
    .CLK(CLK), .RES(RES), .IVALID(IVALID), .IREADY(IREADY),
    .OPCODE(OPCODE), .RD(RD), .RS1(RS1), .RS2(RS2), .FUNCT3(FUNCT3),
    .FUNCT7(FUNCT7), .IMM(IMM), .OVALID(OVALID), .OREADY(OREADY),
    .ODATA(ODATA), .OERR(OERR), .ENCCNT(ENCCNT), .ERRCNT(ERRCNT)
  );

  typedef enum {K_R, K_I, K_S, K_B, K_U, K_J} kind_t;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    bit          has_exp;
    logic [31:0] exp_data;
    bit          exp_err;
  } req_t;

  req_t        sb[$];
  req_t        cur;
  req_t        vec[13];
  req_t        burst[5];
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_enc = 0;
  int unsigned exp_err_cnt = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_err;
  bit          acc = 1'b0;
  bit          del = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic kind_t kind_of(input logic [6:0] op);
    case (op)
      7'b0100011:             return K_S;
      7'b1100011:             return K_B;
      7'b1101111:             return K_J;
      7'b0110111, 7'b0010111: return K_U;
      7'b0000011, 7'b0010011,
      7'b1100111:             return K_I;
      default:                return K_R;
    endcase
  endfunction

  function automatic bit legal(input kind_t k, input logic [31:0] imm);
    longint v;
    v = longint'($signed(imm));
    case (k)
      K_I, K_S: return (v >= -2048) && (v <= 2047);
      K_B:      return (v >= -4096) && (v <= 4095) && (imm[0] == 1'b0);
      K_J:      return (v >= -1048576) && (v <= 1048575) && (imm[0] == 1'b0);
      K_U:      return (imm % 4096) == 0;
      default:  return 1'b1;
    endcase
  endfunction

  // Value the decoder should recover: the immediate reduced to the format's field.
  function automatic logic [31:0] wrap_imm(input kind_t k, input logic [31:0] imm);
    longint v;
    longint w;
    v = longint'($signed(imm));
    w = v;
    case (k)
      K_I, K_S: begin w = v & 4095;    if (w >= 2048)    w -= 4096;    end
      K_B:      begin w = v & 8190;    if (w >= 4096)    w -= 8192;    end
      K_J:      begin w = v & 2097150; if (w >= 1048576) w -= 2097152; end
      K_U:      w = v - (v & 4095);
      default:  w = v;
    endcase
    return w[31:0];
  endfunction

  function automatic logic [31:0] decode(input kind_t k, input logic [31:0] w);
    case (k)
      K_I:     return {{20{w[31]}}, w[31:20]};
      K_S:     return {{20{w[31]}}, w[31:25], w[11:7]};
      K_B:     return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      K_J:     return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      K_U:     return {w[31:12], 12'h000};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] field_mask(input kind_t k);
    case (k)
      K_I:      return 32'h000F_FFFF;
      K_S, K_B: return 32'h01FF_F07F;
      K_U, K_J: return 32'h0000_0FFF;
      default:  return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic check_word(input req_t r, input logic [31:0] data, input logic err);
    kind_t       k;
    logic [31:0] fields;
    k = kind_of(r.op);
    fields = {r.f7, r.rs2, r.rs1, r.f3, r.rd, r.op};
    check("fields", data & field_mask(k), fields & field_mask(k));
    if (k != K_R) check("imm_roundtrip", decode(k, data), wrap_imm(k, r.imm));
    check("oerr", 32'(err), 32'(!legal(k, r.imm)));
    if (r.has_exp) begin
      check("vec_odata", data, r.exp_data);
      check("vec_oerr", 32'(err), 32'(r.exp_err));
    end
  endtask

  function automatic req_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm, input logic [31:0] exp_data, input bit exp_err);
    req_t r;
    r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3; r.f7 = f7; r.imm = imm;
    r.has_exp = 1'b1; r.exp_data = exp_data; r.exp_err = exp_err;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t        r;
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 8))
      0: r.op = 7'b0100011;
      1: r.op = 7'b1100011;
      2: r.op = 7'b1101111;
      3: r.op = 7'b0110111;
      4: r.op = 7'b0010111;
      5: r.op = 7'b0000011;
      6: r.op = 7'b0010011;
      7: r.op = 7'b1100111;
      default: r.op = 7'($urandom);
    endcase
    r.rd = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom);
    r.f3 = 3'($urandom); r.f7 = 7'($urandom);
    if ($urandom_range(0, 4) == 0) r.imm = $urandom;
    else begin
      case (kind_of(r.op))
        K_I, K_S: r.imm = {{20{x[11]}}, x[11:0]};
        K_B:      r.imm = {{19{x[12]}}, x[12:1], 1'b0};
        K_J:      r.imm = {{11{x[20]}}, x[20:1], 1'b0};
        K_U:      r.imm = {x[31:12], 12'h000};
        default:  r.imm = x;
      endcase
    end
    r.has_exp = 1'b0; r.exp_data = '0; r.exp_err = 1'b0;
    return r;
  endfunction

  task automatic drive(input req_t r);
    cur = r;
    OPCODE = r.op; RD = r.rd; RS1 = r.rs1; RS2 = r.rs2;
    FUNCT3 = r.f3; FUNCT7 = r.f7; IMM = r.imm;
  endtask

  // One clock cycle: entered at a falling edge with inputs already driven.
  task automatic step();
    req_t r;
    #1;
    if (prev_stall && OVALID) begin
      check("hold_odata", ODATA, prev_data);
      check("hold_oerr", 32'(OERR), 32'(prev_err));
    end
    check("enccnt", 32'(ENCCNT), exp_enc % (1 << CNTW));
    check("errcnt", 32'(ERRCNT), exp_err_cnt);
    acc = IVALID && IREADY;
    del = OVALID && OREADY;
    if (acc) sb.push_back(cur);
    if (del) begin
      if (sb.size() == 0) check("word_without_request", 32'(OVALID), 32'(0));
      else begin
        r = sb.pop_front();
        check_word(r, ODATA, OERR);
      end
      exp_enc++;
      if (OERR && exp_err_cnt < (1 << CNTW) - 1) exp_err_cnt++;
    end
    prev_stall = OVALID && !OREADY;
    prev_data  = ODATA;
    prev_err   = OERR;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    IVALID = 1'b0; OREADY = 1'b0; RES = 1'b0;
    sb.delete(); exp_enc = 0; exp_err_cnt = 0; prev_stall = 1'b0; acc = 1'b0; del = 1'b0;
    @(negedge CLK);
    check("rst_ovalid", 32'(OVALID), 32'(0));
    check("rst_odata", ODATA, 32'(0));
    check("rst_oerr", 32'(OERR), 32'(0));
    check("rst_enccnt", 32'(ENCCNT), 32'(0));
    check("rst_errcnt", 32'(ERRCNT), 32'(0));
    @(negedge CLK);
    RES = 1'b1;
    #1 check("iready_after_reset", 32'(IREADY), 32'(1));
    @(negedge CLK);
  endtask

  initial begin
    int n;
    int lat;
    int idx;
    int dcount;
    int cycles;
    int accepted;

    vec[0]  = mk(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0);
    vec[1]  = mk(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
    vec[2]  = mk(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0003, 32'h0020_8163, 1'b1);
    vec[3]  = mk(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0);
    vec[4]  = mk(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'h8000_00EF, 1'b1);
    vec[5]  = mk(7'b0110111, 5'd5, 5'd7, 5'd3, 3'd3, 7'd9, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    vec[6]  = mk(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h1234_52B7, 1'b1);
    vec[7]  = mk(7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4031_00B3, 1'b0);
    vec[8]  = mk(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'h0000_0008, 32'h0020_A423, 1'b0);
    vec[9]  = mk(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'h0000_0800, 32'h8020_A023, 1'b1);
    vec[10] = mk(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'h0000_07FF, 32'h7FF1_0093, 1'b0);
    vec[11] = mk(7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8001_0093, 1'b0);
    vec[12] = mk(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFE, 32'hFFFF_F0EF, 1'b0);

    @(negedge CLK);
    do_reset();

    // Directed table, one word at a time, acceptance-to-output latency of two cycles.
    OREADY = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(vec[i]);
      IVALID = 1'b1;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 20) begin step(); n++; end
      check("vec_accepted", 32'(acc), 32'(1));
      IVALID = 1'b0;
      lat = 0;
      del = 1'b0;
      while (!del && lat < 20) begin step(); lat++; end
      check("vec_latency", lat, 2);
    end
    step();

    // Backpressure: only two requests fit while the output is stalled.
    do_reset();
    for (int i = 0; i < 5; i++) burst[i] = rand_req();
    idx = 0;
    OREADY = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 5) begin drive(burst[idx]); IVALID = 1'b1; end else IVALID = 1'b0;
      step();
      if (acc) idx++;
    end
    check("accepted_under_stall", idx, 2);
    #1 check("iready_low_when_full", 32'(IREADY), 32'(0));
    OREADY = 1'b1;
    dcount = 0;
    cycles = 0;
    while (dcount < 5 && cycles < 20) begin
      if (idx < 5) begin drive(burst[idx]); IVALID = 1'b1; end else IVALID = 1'b0;
      step();
      if (acc) idx++;
      if (del) dcount++;
      cycles++;
    end
    IVALID = 1'b0;
    check("burst_delivered", dcount, 5);
    check("burst_cycles", cycles, 5);
    step();
    check("enccnt_after_burst", 32'(ENCCNT), 32'(5));

    // Asynchronous reset with both stages occupied.
    OREADY = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      if (idx < 2) begin drive(rand_req()); IVALID = 1'b1; end else IVALID = 1'b0;
      step();
      if (acc) idx++;
    end
    check("both_stages_full", 32'(OVALID && !IREADY), 32'(1));
    #2 RES = 1'b0;
    #1;
    check("async_ovalid", 32'(OVALID), 32'(0));
    check("async_odata", ODATA, 32'(0));
    check("async_oerr", 32'(OERR), 32'(0));
    check("async_enccnt", 32'(ENCCNT), 32'(0));
    check("async_errcnt", 32'(ERRCNT), 32'(0));
    sb.delete(); exp_enc = 0; exp_err_cnt = 0; prev_stall = 1'b0;
    IVALID = 1'b0; OREADY = 1'b1;
    @(negedge CLK);
    RES = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("flushed_ovalid", 32'(OVALID), 32'(0));
    end

    // Randomized traffic with random backpressure; narrow counters wrap and saturate.
    accepted = 0;
    cycles = 0;
    acc = 1'b0;
    IVALID = 1'b0;
    while (accepted < 10000 && cycles < 80000) begin
      if (!IVALID || acc) begin
        if ($urandom_range(0, 3) != 0) begin drive(rand_req()); IVALID = 1'b1; end
        else IVALID = 1'b0;
      end
      OREADY = ($urandom_range(0, 3) != 0);
      step();
      if (acc) accepted++;
      cycles++;
    end
    check("random_accepted", accepted, 10000);
    IVALID = 1'b0;
    OREADY = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 20) begin step(); n++; end
    check("drained", sb.size(), 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
